binary_to_rns: RTL
==================

# binary_to_rns

- Converts an unsigned binary integer into the 9-bit residue number system (RNS) word used across the codebase: moduli 8, 7 and 5, N = 280, packed as {r8[8:6], r7[5:3], r5[2:0]}.
- It is the forward converter, feeding RNS arithmetic blocks.
- Residues are computed bit-serially, MSB first, using Horner reduction in three parallel accumulators.
- Input and output each use a valid/ready handshake.

## Interface

Parameters:
- W, 32: input width in bits. Must be at least 9.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  reset, asynchronous, active-high
- in_data  input  W  unsigned binary value to convert
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts a new value; high only in IDLE
- out_bits  output  9  RNS result {x mod 8, x mod 7, x mod 5}
- out_overflow  output  1  accepted value was ≥ 280, so out_bits represents x mod 280
- out_valid  output  1  out_bits and out_overflow are valid
- out_ready  input  1  consumer takes the result

## Operation

State machine with three states: IDLE, SHIFT, DONE.

- **IDLE**
  - in_ready=1.
  - On in_valid && in_ready:
    - latch in_data into shift register sh;
    - clear all accumulators to 0;
    - load bit counter cnt=W-1;
    - register out_overflow = (in_data ≥ 280);
    - go to SHIFT.
- **SHIFT**
  - Each cycle, b = sh[W-1]. Every accumulator m ∈ {8,7,5} updates r ← t ≥ m ? t−m : t, where t = 2r+b.
  - sh shifts left by one.
  - When cnt==0, go to DONE. Otherwise decrement cnt.
- **DONE**
  - out_valid=1.
  - out_bits = {r8[2:0], r7[2:0], r5[2:0]}, held stable.
  - On out_ready, go to IDLE.

Arithmetic and widths:
- Each accumulator r is 3 bits, with invariant r < m.
- t is 4 bits. A single conditional subtraction suffices.
- The mod-8 path uses the same update rule for uniformity. Its result must equal in_data[2:0].

Boundary conditions:
- in_valid while not IDLE: ignored; in_ready=0.
- out_ready while not DONE: ignored.
- out_ready low in DONE: hold out_bits, out_overflow and out_valid indefinitely.
- Value 0 gives out_bits=0 and overflow=0. Values ≥ 280 are reduced correctly, with overflow set.
- Reset mid-operation: immediately return to IDLE. The in-flight value is lost and no output is produced.

Reset values:
- state=IDLE, in_ready=1, out_valid=0, out_bits=0, out_overflow=0.
- Internal sh, cnt and accumulators all 0.

## Timing

- Accept edge k is the rising edge where in_valid && in_ready.
- SHIFT occupies edges k+1 … k+W.
- out_valid is high after edge k+W, so latency is W cycles: 32 for the default width.
- Output is consumed on the first edge with out_valid && out_ready. out_valid drops and in_ready rises after that edge.
- The next accept can occur one cycle later.
- Throughput: one conversion per W+2 cycles when out_ready is held high.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Structure

Shared package rns_pkg holds:
- RNS_N=280;
- moduli M8=8, M7=7, M5=5;
- field ranges for r8 [8:6], r7 [5:3], r5 [2:0];
- RNS_BITS=9.

This package is also to be used by the RNS-to-binary side.

Sub-module rns_mod_accum (parameter MOD; ports clock, reset, clear, en, bit_in, r[2:0]) implements one Horner residue register. It is instantiated three times. FSM, counter, shift register and handshake live in the top module.

## Test plan

1. in_data=78, out_ready=1 → out_valid exactly 32 cycles after accept; out_bits=9'b110_001_011; overflow=0.
2. Back-to-back 3 then 123 → 9'b011_011_011, then 9'b011_100_011. Second accept occurs one cycle after the first output handshake.
3. Boundaries:
   - 0 → 9'b000_000_000, overflow=0;
   - 279 → 9'b111_110_100, overflow=0;
   - 280 → 9'b000_000_000, overflow=1;
   - 0xFFFFFFFF → 9'b111_011_000, overflow=1.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE → out_bits stable and in_ready=0 throughout. Pulsing in_valid with new data is ignored. Raising out_ready completes the original result.
5. Assert reset at cycle 10 of SHIFT → in_ready=1 and out_valid=0 immediately. Next conversion of 78 yields the correct result.
6. Random sweep of 1000 values → each residue field equals in_data mod 8/7/5 and overflow equals (in_data ≥ 280). Values taken mod 280 round-trip through the RNS-to-binary converter.

Source files
------------

// File: rtl/rns_pkg.sv
// Shared definitions for the 9-bit RNS word (moduli 8, 7, 5; dynamic range 280),
// used by both the forward (binary-to-RNS) and reverse converters.
package rns_pkg;

  localparam int RNS_N    = 280;
  localparam int RNS_BITS = 9;

  localparam int M8 = 8;
  localparam int M7 = 7;
  localparam int M5 = 5;

  localparam int R8_HI = 8;
  localparam int R8_LO = 6;
  localparam int R7_HI = 5;
  localparam int R7_LO = 3;
  localparam int R5_HI = 2;
  localparam int R5_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } b2r_state_t;

endpackage

// File: rtl/binary_to_rns_if.sv
// Input and output handshake bundle for the binary-to-RNS converter.
interface binary_to_rns_if #(
    parameter int W = 32
);
    // Both channels are valid/ready: a transfer happens on a rising edge where
    // valid && ready; valid and its data stay unchanged until that edge, and
    // ready never depends combinationally on valid.
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [8:0]   out_bits;
    logic         out_overflow;
    logic         out_valid;
    logic         out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_bits, out_overflow, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_bits, out_overflow, out_valid
    );
endinterface

// File: rtl/rns_mod_accum.sv
// One Horner residue register: r <- (2r + bit) mod MOD, MSB first, with r < MOD kept invariant.
module rns_mod_accum #(
    parameter int MOD = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [2:0] r
);
    localparam logic [3:0] MODV = 4'(MOD);

    logic [3:0] w_t;

    // Since r < MOD, 2r+b < 2*MOD, so one conditional subtraction restores the invariant.
    always_comb w_t = {r, bit_in};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r <= 3'd0;
        end else if (clear) begin
            r <= 3'd0;
        end else if (en) begin
            r <= 3'((w_t >= MODV) ? (w_t - MODV) : w_t);
        end
    end
endmodule

// File: rtl/binary_to_rns.sv
// Forward RNS converter: shifts the binary input out MSB first through three
// parallel residue accumulators (mod 8, 7, 5) and presents the packed result.
module binary_to_rns
    import rns_pkg::*;
#(
    parameter int W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    binary_to_rns_if.slave        bus,
    output b2r_state_t            o_state
);
    localparam int CW = $clog2(W);

    b2r_state_t   r_state;
    logic [W-1:0] r_sh;
    logic [CW-1:0] r_cnt;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_overflow;

    logic         w_clear;
    logic         w_en;
    logic         w_bit;
    logic [2:0]   w_r8;
    logic [2:0]   w_r7;
    logic [2:0]   w_r5;

    assign w_clear = (r_state == ST_IDLE) && bus.in_valid;
    assign w_en    = (r_state == ST_SHIFT);
    assign w_bit   = r_sh[W-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sh        <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_sh       <= bus.in_data;
                        r_cnt      <= CW'(W - 1);
                        r_overflow <= (bus.in_data >= W'(RNS_N));
                        r_in_ready <= 1'b0;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_sh <= r_sh << 1;
                    if (r_cnt == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    rns_mod_accum #(.MOD(M8)) u_acc8 (
        .clock(clock), .reset(reset), .clear(w_clear), .en(w_en), .bit_in(w_bit), .r(w_r8)
    );
    rns_mod_accum #(.MOD(M7)) u_acc7 (
        .clock(clock), .reset(reset), .clear(w_clear), .en(w_en), .bit_in(w_bit), .r(w_r7)
    );
    rns_mod_accum #(.MOD(M5)) u_acc5 (
        .clock(clock), .reset(reset), .clear(w_clear), .en(w_en), .bit_in(w_bit), .r(w_r5)
    );

    // Accumulators are frozen outside SHIFT, so the packed word is held through DONE.
    assign bus.out_bits     = {w_r8, w_r7, w_r5};
    assign bus.out_overflow = r_overflow;
    assign bus.out_valid    = r_out_valid;
    assign bus.in_ready     = r_in_ready;
    assign o_state          = r_state;
endmodule
